// File: rtl/cpu_defs_pkg.sv
// Shared fetch-stage constants and types for the 5-stage MIPS core.
package cpu_defs_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_VALID = 1'b1
  } fetch_state_t;

  // Sequential successor; wraps naturally modulo 2^32.
  function automatic logic [31:0] pc_plus_4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory request/ack bus between the fetch controller and IM.
interface fetch_pc_ctrl_if;

  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (output im_req, output im_addr, input im_ack, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);

endinterface

// File: rtl/fetch_pc_ctrl_redirect_latch.sv
// Holds a D-stage redirect that arrived before its delay-slot word was accepted.
module redirect_latch
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic        accept,
  input  logic [31:0] tgt_in,
  output logic        pend,
  output logic [31:0] tgt
);

  logic        pend_reg;
  logic [31:0] tgt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_reg <= 1'b0;
      tgt_reg  <= 32'h0;
    end else begin
      // A second redirect before any delay slot was consumed means D misbehaved.
      assert (!(redirect && pend_reg));
      if (redirect && !accept) begin
        pend_reg <= 1'b1;
        tgt_reg  <= tgt_in;
      end else if (accept) begin
        pend_reg <= 1'b0;
      end
    end
  end

  assign pend = pend_reg;
  assign tgt  = tgt_reg;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC owner: one outstanding IM request, registered F word, delay-slot redirects.
module fetch_pc_ctrl
  import cpu_defs_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             npc_sel,
  input  logic [31:0]      npc,
  fetch_pc_ctrl_if.master  im,
  output logic             F_valid,
  output logic [31:0]      F_pc,
  output logic [31:0]      F_instr,
  output logic [31:0]      F_pc_add_4
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  f_pc_reg, f_pc_next;
  logic [31:0]  f_instr_reg, f_instr_next;
  logic         f_valid_reg, f_valid_next;
  logic         redirect, accept;
  logic         redir_pend;
  logic [31:0]  redir_tgt;

  assign redirect = npc_sel && !stall;
  assign accept   = (state_reg == S_VALID) && !stall;

  redirect_latch u_redirect_latch (
    .clk      (clk),
    .reset    (reset),
    .redirect (redirect),
    .accept   (accept),
    .tgt_in   (npc),
    .pend     (redir_pend),
    .tgt      (redir_tgt)
  );

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    f_pc_next    = f_pc_reg;
    f_instr_next = f_instr_reg;
    f_valid_next = f_valid_reg;
    im.im_req    = 1'b0;
    im.im_addr   = pc_reg;
    case (state_reg)
      S_FETCH: begin
        im.im_req = reset;
        if (im.im_ack) begin
          f_instr_next = im.im_rdata;
          f_pc_next    = pc_reg;
          f_valid_next = 1'b1;
          state_next   = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          // Same-cycle redirect beats a buffered one, which beats sequential flow.
          if (redirect)        pc_next = npc;
          else if (redir_pend) pc_next = redir_tgt;
          else                 pc_next = pc_plus_4(f_pc_reg);
          f_valid_next = 1'b0;
          f_instr_next = NOP_INSTR;
          state_next   = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      f_pc_reg    <= RESET_PC;
      f_instr_reg <= NOP_INSTR;
      f_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      f_pc_reg    <= f_pc_next;
      f_instr_reg <= f_instr_next;
      f_valid_reg <= f_valid_next;
    end
  end

  assign F_valid    = f_valid_reg;
  assign F_pc       = f_pc_reg;
  assign F_instr    = f_instr_reg;
  assign F_pc_add_4 = pc_plus_4(f_pc_reg);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: per-cycle behavioural model plus literal scenario checks.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        npc_sel = 1'b0;
  logic [31:0] npc = 32'h0;
  logic        F_valid;
  logic [31:0] F_pc, F_instr, F_pc_add_4;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;

  fetch_pc_ctrl_if im_bus ();

  fetch_pc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .npc        (npc),
    .im         (im_bus),
    .F_valid    (F_valid),
    .F_pc       (F_pc),
    .F_instr    (F_instr),
    .F_pc_add_4 (F_pc_add_4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: answers after ack_delay waiting cycles of a held request.
  initial begin
    int wcnt;
    wcnt = 0;
    im_bus.im_ack   = 1'b0;
    im_bus.im_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset || !im_bus.im_req) begin
        im_bus.im_ack = 1'b0;
        wcnt = 0;
      end else if (wcnt >= ack_delay) begin
        im_bus.im_ack   = 1'b1;
        im_bus.im_rdata = mem_word(im_bus.im_addr);
        wcnt = 0;
      end else begin
        im_bus.im_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Behavioural model: "holding a word" or "waiting on memory", plus a pending target.
  logic        armed = 1'b0;
  logic        m_hold, m_pend;
  logic [31:0] m_pc, m_fpc, m_finstr, m_tgt;
  logic [31:0] fetch_log[$];

  initial begin
    logic s_reset, s_stall, s_sel, s_ack, redir;
    logic [31:0] s_npc, s_rdata;
    forever begin
      @(posedge clk);
      s_reset = reset; s_stall = stall; s_sel = npc_sel; s_npc = npc;
      s_ack = im_bus.im_ack; s_rdata = im_bus.im_rdata;
      if (!s_reset) begin
        armed = 1'b1; m_hold = 1'b0; m_pend = 1'b0; m_tgt = 32'h0;
        m_pc = RST_PC; m_fpc = RST_PC; m_finstr = NOP;
        fetch_log.delete();
      end else if (armed) begin
        redir = s_sel && !s_stall;
        if (m_hold) begin
          if (!s_stall) begin
            if (redir) m_pc = s_npc;
            else if (m_pend) begin m_pc = m_tgt; m_pend = 1'b0; end
            else m_pc = m_fpc + 32'd4;
            m_hold = 1'b0;
            m_finstr = NOP;
          end
        end else begin
          if (redir) begin m_pend = 1'b1; m_tgt = s_npc; end
          if (s_ack) begin
            m_finstr = s_rdata; m_fpc = m_pc; m_hold = 1'b1;
            fetch_log.push_back(m_pc);
          end
        end
      end
      #1;
      if (armed) begin
        chk("m_F_valid", {31'h0, F_valid}, {31'h0, m_hold});
        chk("m_F_pc", F_pc, m_fpc);
        chk("m_F_instr", F_instr, m_hold ? m_finstr : NOP);
        chk("m_F_pc_add_4", F_pc_add_4, m_fpc + 32'd4);
        chk("m_im_req", {31'h0, im_bus.im_req}, {31'h0, reset && !m_hold});
        if (reset && !m_hold) chk("m_im_addr", im_bus.im_addr, m_pc);
      end
    end
  end

  task automatic wait_valid(input logic [31:0] a);
    int n = 0;
    while (!(F_valid && F_pc == a) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("timeout_valid", F_pc, a);
  endtask

  task automatic wait_fetch(input logic [31:0] a);
    int n = 0;
    while (!(im_bus.im_req && im_bus.im_addr == a) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("timeout_fetch", im_bus.im_addr, a);
  endtask

  task automatic wait_log(input int cnt);
    int n = 0;
    while (fetch_log.size() < cnt && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("timeout_log", fetch_log.size(), cnt);
  endtask

  initial begin
    // Reset, then a 3-cycle held request at 0x3000.
    ack_delay = 2;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, F_valid}, 32'h0);
    chk("rst_req", {31'h0, im_bus.im_req}, 32'h0);
    chk("rst_pc", F_pc, 32'h0000_3000);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dly_req", {31'h0, im_bus.im_req}, 32'h1);
      chk("dly_addr", im_bus.im_addr, 32'h0000_3000);
      chk("dly_valid", {31'h0, F_valid}, 32'h0);
    end
    @(negedge clk);
    chk("dly_done_valid", {31'h0, F_valid}, 32'h1);
    chk("dly_done_instr", F_instr, mem_word(32'h0000_3000));
    chk("dly_done_req", {31'h0, im_bus.im_req}, 32'h0);
    ack_delay = 0;

    // Redirect on an accepted word: 0x3004 is the delay slot, then 0x3040.
    wait_valid(32'h0000_3004);
    npc_sel = 1'b1; npc = 32'h0000_3040;
    @(negedge clk);
    npc_sel = 1'b0;
    wait_log(3);
    if (fetch_log.size() >= 3) chk("redir_now_log2", fetch_log[2], 32'h0000_3040);

    // Fresh reset with same-cycle acks; redirect while 0x3008 is still being fetched.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_fetch(32'h0000_3008);
    npc_sel = 1'b1; npc = 32'h0000_3100;
    @(negedge clk);
    npc_sel = 1'b0;
    wait_log(5);
    if (fetch_log.size() >= 5) begin
      chk("seq_log0", fetch_log[0], 32'h0000_3000);
      chk("seq_log1", fetch_log[1], 32'h0000_3004);
      chk("seq_log2", fetch_log[2], 32'h0000_3008);
      chk("pend_log3", fetch_log[3], 32'h0000_3100);
      chk("pend_clr_log4", fetch_log[4], 32'h0000_3104);
    end

    // Stall for 4 cycles with a redirect presented that must be ignored.
    wait_valid(32'h0000_3104);
    stall = 1'b1; npc_sel = 1'b1; npc = 32'h0000_5000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'h0, F_valid}, 32'h1);
      chk("stall_pc", F_pc, 32'h0000_3104);
      chk("stall_instr", F_instr, mem_word(32'h0000_3104));
      chk("stall_req", {31'h0, im_bus.im_req}, 32'h0);
    end
    stall = 1'b0; npc_sel = 1'b0;
    wait_log(6);
    if (fetch_log.size() >= 6) chk("stall_next_log5", fetch_log[5], 32'h0000_3108);

    // Wrap at the top of the address space.
    wait_valid(32'h0000_3108);
    npc_sel = 1'b1; npc = 32'hFFFF_FFFC;
    @(negedge clk);
    npc_sel = 1'b0;
    wait_valid(32'hFFFF_FFFC);
    chk("wrap_add4", F_pc_add_4, 32'h0000_0000);
    chk("wrap_instr", F_instr, mem_word(32'hFFFF_FFFC));
    wait_log(8);
    if (fetch_log.size() >= 8) chk("wrap_log7", fetch_log[7], 32'h0000_0000);

    // Reset abandons an outstanding fetch at 0x3010.
    wait_valid(32'h0000_0000);
    ack_delay = 3;
    npc_sel = 1'b1; npc = 32'h0000_3010;
    @(negedge clk);
    npc_sel = 1'b0;
    wait_fetch(32'h0000_3010);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'h0, F_valid}, 32'h0);
    chk("midrst_req", {31'h0, im_bus.im_req}, 32'h0);
    ack_delay = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'h0, im_bus.im_req}, 32'h1);
    chk("post_rst_addr", im_bus.im_addr, 32'h0000_3000);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
